// File: rtl/posit_arith_pkg.sv
// Shared arithmetic helpers for the posit datapath: Kogge-Stone pipe sizing
// and the default-width stage payload layout.
package posit_arith_pkg;

    function automatic int ksa_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int KSA_WIDIDX = 3;
    localparam int KSA_LPS    = 2;
    localparam int KSA_W      = 1 << KSA_WIDIDX;
    localparam int KSA_N      = ksa_ceil_div(KSA_WIDIDX, KSA_LPS);

    // Payload carried between prefix stages at the default width.
    typedef struct packed {
        logic [KSA_W-1:0] p;
        logic [KSA_W-1:0] g;
        logic [KSA_W-1:0] p0;
        logic             op;
    } ksa_stage_t;

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone level: merges each bit's group (P,G) with the
// group SPAN bits below it; bits below SPAN pass through unchanged.
module ksa_prefix_level #(
    parameter int WIDIDX = 3,
    parameter int SPAN   = 1
) (
    input  logic [(1<<WIDIDX)-1:0] i_p,
    input  logic [(1<<WIDIDX)-1:0] i_g,
    output logic [(1<<WIDIDX)-1:0] o_p,
    output logic [(1<<WIDIDX)-1:0] o_g
);

    localparam int W = 1 << WIDIDX;

    for (genvar j = 0; j < W; j++) begin : g_bit
        if (j >= SPAN) begin : g_merge
            assign o_g[j] = i_g[j] | (i_p[j] & i_g[j-SPAN]);
            assign o_p[j] = i_p[j] & i_p[j-SPAN];
        end else begin : g_pass
            assign o_g[j] = i_g[j];
            assign o_p[j] = i_p[j];
        end
    end

endmodule

// File: rtl/ksa_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides;
// register stages wrap groups of LPS prefix levels.
module ksa_addsub_pipe
    import posit_arith_pkg::*;
#(
    parameter int WIDIDX = KSA_WIDIDX,
    parameter int LPS    = KSA_LPS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [(1<<WIDIDX)-1:0]  in_a,
    input  logic [(1<<WIDIDX)-1:0]  in_b,
    input  logic                    in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<WIDIDX)-1:0]  out_res,
    output logic                    out_cb,
    output logic                    out_zf
);

    localparam int W = 1 << WIDIDX;
    localparam int N = ksa_ceil_div(WIDIDX, LPS);

    // Same layout as ksa_stage_t, sized to this instance's width.
    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] g;
        logic [W-1:0] p0;
        logic         op;
    } stage_t;

    logic [N:0]   r_vld;
    logic [N:0]   w_adv;
    logic [N:0]   w_load;
    logic         w_accept;

    logic [W-1:0] w_b_in;
    logic [W-1:0] w_p_in;
    logic [W-1:0] w_g_in;

    stage_t       w_pay_q [0:N-1];
    logic [W-1:0] w_lin_p [1:WIDIDX];
    logic [W-1:0] w_lin_g [1:WIDIDX];
    logic [W-1:0] w_lp    [1:WIDIDX];
    logic [W-1:0] w_lg    [1:WIDIDX];

    logic [W-1:0] w_res;
    logic         w_cb;
    logic [W-1:0] r_res;
    logic         r_cb;
    logic         r_zf;

    // Subtraction is A + ~B + 1; the carry-in is folded into bit 0's generate.
    assign w_b_in = in_op ? ~in_b : in_b;
    assign w_p_in = in_a ^ w_b_in;
    assign w_g_in = {(in_a[W-1:1] & w_b_in[W-1:1]),
                     (in_a[0] & w_b_in[0]) | (w_p_in[0] & in_op)};

    // NOTE: the stall chain is evaluated top-down in one block with a default
    // first, so no bit is ever left unassigned and no latch is inferred.
    always_comb begin
        w_adv    = '0;
        w_adv[N] = r_vld[N] & out_ready;
        for (int k = N - 1; k >= 0; k--) begin
            w_adv[k] = r_vld[k] & (~r_vld[k+1] | w_adv[k+1]);
        end
    end

    assign in_ready = ~r_vld[0] | w_adv[0];
    assign w_accept = in_valid & in_ready;
    assign w_load   = {w_adv[N-1:0], w_accept};

    // NOTE: state updates use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; reset is asynchronous on all of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k <= N; k++) begin
                r_vld[k] <= w_load[k] | (r_vld[k] & ~w_adv[k]);
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stg
        stage_t r_pay;
        stage_t w_next;

        if (k == 0) begin : g_in
            assign w_next = {w_p_in, w_g_in, w_p_in, in_op};
        end else begin : g_mid
            assign w_next = {w_lp[k*LPS], w_lg[k*LPS],
                             w_pay_q[k-1].p0, w_pay_q[k-1].op};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pay <= '0;
            end else if (w_load[k]) begin
                r_pay <= w_next;
            end
        end

        assign w_pay_q[k] = r_pay;
    end

    // Level l runs in stage (l-1)/LPS + 1; the first level of a group reads
    // the preceding register, the rest chain combinationally.
    for (genvar l = 1; l <= WIDIDX; l++) begin : g_lvl
        localparam int STG = (l - 1) / LPS + 1;

        if ((l - 1) % LPS == 0) begin : g_head
            assign w_lin_p[l] = w_pay_q[STG-1].p;
            assign w_lin_g[l] = w_pay_q[STG-1].g;
        end else begin : g_chain
            assign w_lin_p[l] = w_lp[l-1];
            assign w_lin_g[l] = w_lg[l-1];
        end

        ksa_prefix_level #(
            .WIDIDX (WIDIDX),
            .SPAN   (1 << (l - 1))
        ) u_lvl (
            .i_p (w_lin_p[l]),
            .i_g (w_lin_g[l]),
            .o_p (w_lp[l]),
            .o_g (w_lg[l])
        );
    end

    assign w_res = w_pay_q[N-1].p0 ^ {w_lg[WIDIDX][W-2:0], w_pay_q[N-1].op};
    assign w_cb  = w_pay_q[N-1].op ^ w_lg[WIDIDX][W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
            r_cb  <= 1'b0;
            r_zf  <= 1'b0;
        end else if (w_load[N]) begin
            r_res <= w_res;
            r_cb  <= w_cb;
            r_zf  <= (w_res == '0);
        end
    end

    assign out_valid = r_vld[N];
    assign out_res   = r_res;
    assign out_cb    = r_cb;
    assign out_zf    = r_zf;

endmodule
